scope_host: RTL and testbench

//  Master-side sequencer for the scope byte command protocol: drives select/drequest/mosi into the

---
 rtl/scope_host.sv | 245 ++++++++++++++++++++++++
 tb/tb_scope_host.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scope_host.sv
// Master-side sequencer for the scope byte command protocol: runs the ID/config/arm/poll
// command frames against the acquisition slave and drains its sample buffer onto a valid/ready stream.
module scope_host #(
   parameter int NSIG  = 1,
   parameter int NSAMP = 4,
   parameter int NTIME = 3,
   parameter int GAP   = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic                        abort,
   input  logic [NSAMP-1:0]            npost_cfg,
   input  logic [3*NSIG-1:0]           trig_cfg,
   input  logic                        use_sim,
   output logic                        select,
   output logic                        drequest,
   output logic [7:0]                  mosi,
   input  logic [7:0]                  miso,
   output logic                        busy,
   output logic                        error,
   output logic                        fin,
   output logic [NSIG+NTIME:0]         smp_data,
   output logic                        smp_valid,
   input  logic                        smp_ready
);

   localparam int NBITS  = NSIG + NTIME + 1;
   localparam int NBYTES = (NBITS - 1) / 8 + 1;
   localparam int NPB    = (NSAMP - 1) / 8 + 1;
   localparam int NPW    = NPB * 8;
   localparam int WIDE   = NBYTES * 8;
   localparam logic [15:0] WAITLAST = 16'(GAP - 2);
   localparam logic [7:0]  LASTCH   = 8'(NSIG - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_ID, S_POST, S_TRIG, S_CONF, S_ARM, S_POLL, S_DRAIN, S_READ, S_POP
   } state_t;

   // Within a frame: one select-only setup cycle, then strobe/wait pairs, then a select-low end cycle.
   typedef enum logic [1:0] {PH_SETUP, PH_REQ, PH_WAIT, PH_END} phase_t;

   state_t             state_q, state_d;
   phase_t             phase_q, phase_d;
   logic [7:0]         byteIdx_q, byteIdx_d;
   logic [15:0]        waitCnt_q, waitCnt_d;
   logic [7:0]         chCnt_q, chCnt_d;
   logic [NPW-1:0]     npost_q, npost_d;
   logic [3*NSIG-1:0]  trig_q, trig_d;
   logic               sim_q, sim_d;
   logic [7:0]         status_q, status_d;
   logic [NBITS-1:0]   dataBuf_q, dataBuf_d;
   logic               valid_q, valid_d;
   logic               error_q, error_d;
   logic               fin_q, fin_d;

   logic [7:0]         frameLen;
   logic [7:0]         txByte;
   logic [7:0]         idxM1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         phase_q   <= PH_SETUP;
         byteIdx_q <= '0;
         waitCnt_q <= '0;
         chCnt_q   <= '0;
         npost_q   <= '0;
         trig_q    <= '0;
         sim_q     <= 1'b0;
         status_q  <= '0;
         dataBuf_q <= '0;
         valid_q   <= 1'b0;
         error_q   <= 1'b0;
         fin_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         byteIdx_q <= byteIdx_d;
         waitCnt_q <= waitCnt_d;
         chCnt_q   <= chCnt_d;
         npost_q   <= npost_d;
         trig_q    <= trig_d;
         sim_q     <= sim_d;
         status_q  <= status_d;
         dataBuf_q <= dataBuf_d;
         valid_q   <= valid_d;
         error_q   <= error_d;
         fin_q     <= fin_d;
      end
   end

   // Frame length and outgoing byte for the current step and byte position.
   always_comb begin
      frameLen = 8'd1;
      txByte   = 8'h00;
      idxM1    = byteIdx_q - 8'd1;
      case (state_q)
         S_ID: begin
            frameLen = 8'd2;
            txByte   = (byteIdx_q == 8'd0) ? 8'h11 : 8'h00;
         end
         S_POST: begin
            frameLen = 8'(1 + NPB);
            txByte   = (byteIdx_q == 8'd0) ? 8'h15 : 8'(npost_q >> {idxM1, 3'b000});
         end
         S_TRIG: begin
            frameLen = 8'd2;
            txByte   = (byteIdx_q == 8'd0) ? (8'h40 | chCnt_q)
                                           : {5'b00000, 3'(trig_q >> (3 * chCnt_q))};
         end
         S_CONF:  txByte = {7'b0001100, sim_q};
         S_ARM:   txByte = 8'h28;
         S_POLL, S_DRAIN: begin
            frameLen = 8'd2;
            txByte   = (byteIdx_q == 8'd0) ? 8'h14 : 8'h00;
         end
         S_READ: begin
            frameLen = 8'(NBYTES);
            txByte   = (byteIdx_q == 8'd0) ? 8'h16 : 8'h00;
         end
         S_POP:   txByte = 8'h22;
         default: txByte = 8'h00;
      endcase
   end

   assign busy      = (state_q != S_IDLE);
   assign select    = busy && (phase_q != PH_END);
   assign drequest  = busy && (phase_q == PH_REQ);
   assign mosi      = drequest ? txByte : 8'h00;
   assign error     = error_q;
   assign fin       = fin_q;
   assign smp_data  = dataBuf_q;
   assign smp_valid = valid_q;

   // Step sequencing; the decision for each step is taken in its select-low end cycle.
   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      byteIdx_d = byteIdx_q;
      waitCnt_d = waitCnt_q;
      chCnt_d   = chCnt_q;
      npost_d   = npost_q;
      trig_d    = trig_q;
      sim_d     = sim_q;
      status_d  = status_q;
      dataBuf_d = dataBuf_q;
      valid_d   = valid_q;
      error_d   = error_q;
      fin_d     = 1'b0;

      if (valid_q && smp_ready) valid_d = 1'b0;

      if (state_q == S_IDLE) begin
         if (start) begin
            state_d   = S_ID;
            phase_d   = PH_SETUP;
            byteIdx_d = 8'd0;
            npost_d   = NPW'(npost_cfg);
            trig_d    = trig_cfg;
            sim_d     = use_sim;
            error_d   = 1'b0;
         end
      end else begin
         case (phase_q)
            PH_SETUP: phase_d = PH_REQ;
            PH_REQ: begin
               phase_d   = PH_WAIT;
               waitCnt_d = 16'd0;
            end
            PH_WAIT: begin
               if (waitCnt_q == 16'd0) begin
                  if (byteIdx_q == 8'd0 &&
                      (state_q == S_ID || state_q == S_POLL || state_q == S_DRAIN))
                     status_d = miso;
                  if (state_q == S_READ)
                     dataBuf_d = NBITS'((WIDE'(dataBuf_q) & ~(WIDE'(8'hFF) << {byteIdx_q, 3'b000}))
                                        | (WIDE'(miso) << {byteIdx_q, 3'b000}));
               end
               if (waitCnt_q >= WAITLAST) begin
                  if (byteIdx_q == frameLen - 8'd1) begin
                     phase_d = PH_END;
                  end else begin
                     byteIdx_d = byteIdx_q + 8'd1;
                     phase_d   = PH_REQ;
                  end
               end else begin
                  waitCnt_d = waitCnt_q + 16'd1;
               end
            end
            default: begin
               phase_d   = PH_SETUP;
               byteIdx_d = 8'd0;
               case (state_q)
                  S_ID: begin
                     if (status_q != 8'h53) begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                     end else begin
                        state_d = S_POST;
                     end
                  end
                  S_POST: begin
                     state_d = S_TRIG;
                     chCnt_d = 8'd0;
                  end
                  S_TRIG: begin
                     if (chCnt_q == LASTCH) state_d = S_CONF;
                     else chCnt_d = chCnt_q + 8'd1;
                  end
                  S_CONF:  state_d = S_ARM;
                  S_ARM:   state_d = S_POLL;
                  S_POLL:  if (status_q[0]) state_d = S_DRAIN;
                  S_DRAIN: begin
                     if (status_q[2]) begin
                        state_d = S_READ;
                     end else begin
                        fin_d   = 1'b1;
                        state_d = S_IDLE;
                     end
                  end
                  S_READ: begin
                     valid_d = 1'b1;
                     state_d = S_POP;
                  end
                  S_POP: begin
                     if (valid_q && !smp_ready) phase_d = PH_END;
                     else state_d = S_DRAIN;
                  end
                  default: state_d = S_IDLE;
               endcase
            end
         endcase
      end

      // Abort discards any held sample and the frame in progress.
      if (abort) begin
         state_d = S_IDLE;
         phase_d = PH_SETUP;
         valid_d = 1'b0;
         fin_d   = 1'b0;
      end
   end

endmodule

// File: tb/tb_scope_host.sv
// Bench for scope_host: a behavioural acquisition slave answers each strobe, and scoreboard
// queues hold the expected command bytes and the expected sample beats.
module tb_scope_host;

   localparam int NSIG  = 2;
   localparam int NSAMP = 4;
   localparam int NTIME = 9;
   localparam int GAP   = 3;
   localparam int NBITS = NSIG + NTIME + 1;

   logic              clk = 1'b0;
   logic              reset, start, abort, use_sim, smp_ready;
   logic [NSAMP-1:0]  npost_cfg;
   logic [3*NSIG-1:0] trig_cfg;
   logic              select, drequest, busy, error, fin, smp_valid;
   logic [7:0]        mosi;
   logic [7:0]        miso = 8'h00;
   logic [NBITS-1:0]  smp_data;

   int compared   = 0;
   int mismatched = 0;

   logic [7:0]       expQ[$];
   logic [NBITS-1:0] smpQ[$];
   logic [NBITS-1:0] slvBuf[$];
   logic [7:0]       idReply = 8'h53;
   int               pollLeft = 0;
   int               frames = 0;
   int               strobes = 0;
   int               readStrobes = 0;
   int               byteInFrame = 0;
   logic [7:0]       cmd = 8'h00;
   logic [7:0]       resp;
   logic             prevSel = 1'b0;

   scope_host #(.NSIG(NSIG), .NSAMP(NSAMP), .NTIME(NTIME), .GAP(GAP)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .npost_cfg(npost_cfg), .trig_cfg(trig_cfg), .use_sim(use_sim),
      .select(select), .drequest(drequest), .mosi(mosi), .miso(miso),
      .busy(busy), .error(error), .fin(fin),
      .smp_data(smp_data), .smp_valid(smp_valid), .smp_ready(smp_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Slave model plus scoreboard pops for strobed bytes and accepted samples.
   always @(posedge clk) begin
      if (select && !prevSel) frames++;
      if (drequest) begin
         strobes++;
         if (mosi == 8'h16) readStrobes++;
         check("setupSelect", {31'b0, prevSel}, 32'd1);
         check("strobeExpected", {31'b0, expQ.size() != 0}, 32'd1);
         if (expQ.size() != 0) check("mosi", {24'b0, mosi}, {24'b0, expQ.pop_front()});
         resp = 8'h00;
         if (byteInFrame == 0) begin
            cmd = mosi;
            case (mosi)
               8'h11: resp = idReply;
               8'h14: begin
                  resp = {5'b00000, slvBuf.size() != 0, 1'b0, pollLeft == 0};
                  if (pollLeft > 0) pollLeft--;
               end
               8'h16: if (slvBuf.size() != 0) resp = slvBuf[0][7:0];
               8'h22: if (slvBuf.size() != 0) void'(slvBuf.pop_front());
               default: resp = 8'h00;
            endcase
         end else if (cmd == 8'h16 && byteInFrame == 1 && slvBuf.size() != 0) begin
            resp = {4'b0000, slvBuf[0][11:8]};
         end
         miso <= resp;
         byteInFrame++;
      end
      if (!select) byteInFrame = 0;
      if (smp_valid && smp_ready) begin
         check("beatExpected", {31'b0, smpQ.size() != 0}, 32'd1);
         if (smpQ.size() != 0) check("smpData", {20'b0, smp_data}, {20'b0, smpQ.pop_front()});
      end
      prevSel = select;
   end

   task automatic pushSetup(input logic [NSAMP-1:0] np, input logic [3*NSIG-1:0] tr, input logic sim);
      logic [3*NSIG-1:0] t;
      expQ.push_back(8'h11); expQ.push_back(8'h00);
      expQ.push_back(8'h15); expQ.push_back({4'b0000, np});
      t = tr;
      for (int ch = 0; ch < NSIG; ch++) begin
         expQ.push_back(8'h40 + 8'(ch));
         expQ.push_back({5'b00000, t[2:0]});
         t = t >> 3;
      end
      expQ.push_back({7'b0001100, sim});
      expQ.push_back(8'h28);
   endtask

   task automatic pushPolls(input int n);
      for (int i = 0; i < n; i++) begin
         expQ.push_back(8'h14); expQ.push_back(8'h00);
      end
   endtask

   task automatic pushDrain(input int n);
      for (int i = 0; i < n; i++) begin
         expQ.push_back(8'h14); expQ.push_back(8'h00);
         expQ.push_back(8'h16); expQ.push_back(8'h00);
         expQ.push_back(8'h22);
      end
      expQ.push_back(8'h14); expQ.push_back(8'h00);
   endtask

   task automatic loadSample(input logic [NBITS-1:0] s);
      slvBuf.push_back(s);
      smpQ.push_back(s);
   endtask

   task automatic applyStimulus(input logic [NSAMP-1:0] np, input logic [3*NSIG-1:0] tr, input logic sim);
      npost_cfg = np;
      trig_cfg  = tr;
      use_sim   = sim;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic s, input logic d, input logic b);
      check({tag, ".select"},   {31'b0, select},   {31'b0, s});
      check({tag, ".drequest"}, {31'b0, drequest}, {31'b0, d});
      check({tag, ".busy"},     {31'b0, busy},     {31'b0, b});
   endtask

   task automatic waitFin(input int budget);
      int n = 0;
      while (fin !== 1'b1 && n < budget) begin @(negedge clk); n++; end
      check("finSeen", {31'b0, fin}, 32'd1);
   endtask

   initial begin
      int snap;
      int f0;
      reset = 1'b1; start = 1'b0; abort = 1'b0; smp_ready = 1'b1;
      npost_cfg = '0; trig_cfg = '0; use_sim = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset", 1'b0, 1'b0, 1'b0);
      check("reset.mosi",  {24'b0, mosi}, 32'd0);
      check("reset.error", {31'b0, error}, 32'd0);
      check("reset.fin",   {31'b0, fin}, 32'd0);
      check("reset.valid", {31'b0, smp_valid}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Reset in the middle of the ID frame.
      $display("[TB] reset mid-frame");
      pushSetup(4'd5, 6'b101011, 1'b1);
      applyStimulus(4'd5, 6'b101011, 1'b1);
      snap = 0;
      while (drequest !== 1'b1 && snap < 50) begin @(negedge clk); snap++; end
      check("midFrame.strobe", {31'b0, drequest}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("midReset", 1'b0, 1'b0, 1'b0);
      expQ.delete();
      snap = strobes;
      repeat (10) @(negedge clk);
      check("midReset.noStrobes", strobes, snap);

      // Full run with a stalled consumer on the first beat.
      $display("[TB] full run with stall");
      loadSample(12'hA34); loadSample(12'h5C1); loadSample(12'h0FF);
      pollLeft  = 2;
      smp_ready = 1'b0;
      pushSetup(4'd9, 6'b110001, 1'b0);
      pushPolls(3);
      pushDrain(3);
      f0 = frames;
      applyStimulus(4'd9, 6'b110001, 1'b0);
      check("run.busy", {31'b0, busy}, 32'd1);
      applyStimulus(4'd3, 6'b000000, 1'b1);
      snap = 0;
      while (smp_valid !== 1'b1 && snap < 1000) begin @(negedge clk); snap++; end
      check("run.validSeen", {31'b0, smp_valid}, 32'd1);
      check("run.twoByteSample", {20'b0, smp_data}, 32'hA34);
      snap = readStrobes;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("stall.valid", {31'b0, smp_valid}, 32'd1);
         check("stall.data", {20'b0, smp_data}, 32'hA34);
      end
      check("stall.noRead", readStrobes, snap);
      smp_ready = 1'b1;
      waitFin(3000);
      check("run.busyAtFin", {31'b0, busy}, 32'd0);
      check("run.error", {31'b0, error}, 32'd0);
      check("run.bytesLeft", expQ.size(), 32'd0);
      check("run.beatsLeft", smpQ.size(), 32'd0);
      check("run.frames", frames - f0, 32'd19);
      @(negedge clk);
      check("run.finPulse", {31'b0, fin}, 32'd0);

      // Wrong ID reply.
      $display("[TB] ID mismatch");
      idReply = 8'h42;
      expQ.push_back(8'h11); expQ.push_back(8'h00);
      applyStimulus(4'd2, 6'b010010, 1'b0);
      snap = 0;
      while (busy !== 1'b0 && snap < 100) begin @(negedge clk); snap++; end
      check("id.error", {31'b0, error}, 32'd1);
      check("id.busy", {31'b0, busy}, 32'd0);
      check("id.bytesLeft", expQ.size(), 32'd0);

      // Restart clears the error; then abort while polling.
      $display("[TB] abort during poll");
      idReply  = 8'h53;
      pollLeft = 1000;
      pushSetup(4'd7, 6'b011100, 1'b1);
      pushPolls(3);
      applyStimulus(4'd7, 6'b011100, 1'b1);
      check("restart.errorCleared", {31'b0, error}, 32'd0);
      snap = 0;
      while (expQ.size() != 0 && snap < 1000) begin @(negedge clk); snap++; end
      check("poll.reached", expQ.size(), 32'd0);
      check("poll.selectHigh", {31'b0, select}, 32'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checkOutput("abort", 1'b0, 1'b0, 1'b0);
      check("abort.valid", {31'b0, smp_valid}, 32'd0);
      snap = strobes;
      repeat (8) @(negedge clk);
      check("abort.noStrobes", strobes, snap);

      // Next start begins again from the ID frame.
      $display("[TB] restart after abort");
      pollLeft = 0;
      loadSample(12'h123);
      pushSetup(4'd1, 6'b000111, 1'b1);
      pushPolls(1);
      pushDrain(1);
      applyStimulus(4'd1, 6'b000111, 1'b1);
      waitFin(2000);
      check("restart.bytesLeft", expQ.size(), 32'd0);
      check("restart.beatsLeft", smpQ.size(), 32'd0);
      check("restart.busy", {31'b0, busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
